uar: RTL and testbench
======================

// Module: uar
// PURPOSE
//  UART receiver; the receive-side counterpart of the uat transmitter. Oversamples an
//  asynchronous serial line (1 start, 8 data LSB-first, optional parity, 1 stop) and
//  delivers each byte as rx_dout with a one-cycle rx_en strobe, matching the
//  rx_dout/uar_en inputs of dbg_rx_ram. Runs in the clk_7p373m domain next to uat.
// PARAMETERS
//  SAMPLE_RATE  64  clk cycles per bit (clk_rate/baud_rate); even, >=8
//  VERIFY_EN    0   1 = parity bit expected after the data bits and checked
//  VERIFY_MODE  0   0 = even parity, 1 = odd parity (ignored when VERIFY_EN=0)
// PORTS
//  clk            in   1  system clock
//  srst           in   1  synchronous reset, active high
//  rxd            in   1  asynchronous serial input, idle high
//  rx_dout        out  8  last received byte
//  rx_en          out  1  one-cycle strobe: rx_dout and error flags valid
//  rx_parity_err  out  1  parity mismatch for the byte strobed by rx_en
//  rx_frame_err   out  1  stop bit sampled low for the byte strobed by rx_en
//  rx_busy        out  1  high from validated start bit until stop sample
// BEHAVIOUR
//  - Reset: rx_dout=0, rx_en=0, rx_parity_err=0, rx_frame_err=0, rx_busy=0, FSM=IDLE,
//    synchroniser preset to 1. srst mid-frame aborts the frame with no rx_en.
//  - rxd passes through a 2-FF synchroniser; all decisions use the synchronised copy.
//  - Bit counter cnt counts 0..SAMPLE_RATE-1 and wraps; bit index counter 0..7.
//  - FSM: IDLE -> START on synchronised 1->0 edge; cnt cleared.
//    START: at cnt=SAMPLE_RATE/2-1 sample; 0 -> DATA (rx_busy=1, cnt cleared);
//    1 -> IDLE (glitch rejected, no flags).
//    DATA: sample at each cnt wrap (bit centre); shift in LSB first; after bit 7
//    -> PARITY if VERIFY_EN else STOP.
//    PARITY: sample at centre; err = ^{data,p} != VERIFY_MODE; -> STOP.
//    STOP: sample at centre; same cycle rx_dout<=byte, rx_en=1, rx_frame_err=~stop,
//    rx_parity_err=err (0 when VERIFY_EN=0), rx_busy=0.
//    stop=1 -> IDLE; stop=0 -> BREAK.
//  - BREAK: wait for synchronised rxd=1, then IDLE; a held-low line produces exactly
//    one rx_en with rx_frame_err=1.
//  - rx_en asserted even on error; error flags hold until the next rx_en or srst.
//    rx_dout holds between strobes.
//  - Latency: rx_en rises (9+VERIFY_EN)*SAMPLE_RATE + SAMPLE_RATE/2 + 3 cycles after
//    the falling edge at the rxd pin (+-1 for edge alignment).
//  - Back-to-back: FSM is in IDLE by mid-stop-bit, so a start edge at the stop/start
//    boundary is caught with no idle time.
//  - Tolerance: correct reception with sender baud offset up to +-3%.
// TESTING
//  1 SR=64, frame 0xA5, good stop -> one rx_en, rx_dout=8'hA5, both errs 0, rx_busy
//    high exactly during the frame.
//  2 rxd low for 20 clk then high -> no rx_en, rx_busy stays 0, FSM back in IDLE.
//  3 0xFF frame with stop bit driven 0, then line held low 3 bytes -> exactly one rx_en,
//    rx_dout=8'hFF, rx_frame_err=1; next valid frame 0x3C received with flags clear.
//  4 VERIFY_EN=1,VERIFY_MODE=0: 0x07 with parity 1 -> rx_parity_err=0;
//    parity 0 -> rx_parity_err=1. Repeat with VERIFY_MODE=1 -> inverted results.
//  5 bytes 0x00,0x55,0xFF with zero idle between frames, sender at -3% and +3% baud
//    -> three rx_en, data exact.
//  6 srst pulsed during data bit 4 -> no rx_en, all outputs 0; next frame 0x81 -> OK.

Source files
------------

// File: rtl/uar.sv
// uar: oversampling UART receiver (1 start, 8 data LSB-first, optional parity, 1 stop).
// Each received byte is presented on rx_dout with a one-cycle rx_en strobe and error flags.
module uar #(
  parameter int unsigned SAMPLE_RATE = 64,
  parameter int unsigned VERIFY_EN   = 0,
  parameter int unsigned VERIFY_MODE = 0
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       rxd,
  output logic [7:0] rx_dout,
  output logic       rx_en,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned CW = (SAMPLE_RATE > 1) ? $clog2(SAMPLE_RATE) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(SAMPLE_RATE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(SAMPLE_RATE - 1);
  localparam logic PAR_EN  = (VERIFY_EN != 0);
  localparam logic PAR_ODD = (VERIFY_MODE != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        r_state;
  logic [1:0]    r_sync;
  logic          r_prev;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_perr;

  logic w_rxd;
  logic w_fall;
  logic w_half;
  logic w_wrap;

  assign w_rxd  = r_sync[1];
  assign w_fall = r_prev & ~w_rxd;
  assign w_half = (r_cnt == HALF_M1);
  assign w_wrap = (r_cnt == FULL_M1);

  // Two-flop synchroniser plus one-cycle history for falling-edge detection, idle-high.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], rxd};
      r_prev <= w_rxd;
    end
  end

  // Receive FSM; the sample counter free-runs and is re-phased on the start edge.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_shift       <= '0;
      r_perr        <= 1'b0;
      rx_dout       <= '0;
      rx_en         <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      rx_en <= 1'b0;
      r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
      unique case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        S_START: begin
          if (w_half) begin
            r_cnt <= '0;
            if (!w_rxd) begin
              r_state <= S_DATA;
              r_idx   <= '0;
              r_perr  <= 1'b0;
              rx_busy <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (w_wrap) begin
            r_shift <= {w_rxd, r_shift[7:1]};
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              r_state <= PAR_EN ? S_PARITY : S_STOP;
            end
          end
        end
        S_PARITY: begin
          if (w_wrap) begin
            r_perr  <= ((^{r_shift, w_rxd}) != PAR_ODD);
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          // Strobe even on a bad stop bit; a held-low line then parks in S_BREAK.
          if (w_wrap) begin
            rx_dout       <= r_shift;
            rx_en         <= 1'b1;
            rx_frame_err  <= ~w_rxd;
            rx_parity_err <= PAR_EN & r_perr;
            rx_busy       <= 1'b0;
            r_state       <= w_rxd ? S_IDLE : S_BREAK;
          end
        end
        S_BREAK: begin
          if (w_rxd) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uar.sv
// Randomised self-checking bench for uar: a serial-line driver with baud offset feeds
// three receivers (no parity, even, odd); a frame-level model predicts every strobe.
module tb_uar;

  localparam int SR = 64;

  logic       clk = 1'b0;
  logic       srst;
  logic       rxd;
  logic [7:0] dout0, dout1, dout2;
  logic       en0, en1, en2;
  logic       pe0, pe1, pe2;
  logic       fe0, fe1, fe2;
  logic       busy0, busy1, busy2;

  always #5 clk = ~clk;

  uar #(.SAMPLE_RATE(SR), .VERIFY_EN(0), .VERIFY_MODE(0)) u_dut0 (
    .clk(clk), .srst(srst), .rxd(rxd), .rx_dout(dout0), .rx_en(en0),
    .rx_parity_err(pe0), .rx_frame_err(fe0), .rx_busy(busy0)
  );
  uar #(.SAMPLE_RATE(SR), .VERIFY_EN(1), .VERIFY_MODE(0)) u_dut1 (
    .clk(clk), .srst(srst), .rxd(rxd), .rx_dout(dout1), .rx_en(en1),
    .rx_parity_err(pe1), .rx_frame_err(fe1), .rx_busy(busy1)
  );
  uar #(.SAMPLE_RATE(SR), .VERIFY_EN(1), .VERIFY_MODE(1)) u_dut2 (
    .clk(clk), .srst(srst), .rxd(rxd), .rx_dout(dout2), .rx_en(en2),
    .rx_parity_err(pe2), .rx_frame_err(fe2), .rx_busy(busy2)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int en0_cyc;
  int busy0_cnt;

  // Observed and expected strobes, packed as {byte, parity_err, frame_err}.
  logic [9:0] obs0[$], obs1[$], obs2[$];
  logic [9:0] exp0[$], exp1[$], exp2[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (en0) begin
      obs0.push_back({dout0, pe0, fe0});
      en0_cyc = cyc;
    end
    if (en1) obs1.push_back({dout1, pe1, fe1});
    if (en2) obs2.push_back({dout2, pe2, fe2});
    if (busy0) busy0_cnt = busy0_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q();
    obs0.delete(); obs1.delete(); obs2.delete();
    exp0.delete(); exp1.delete(); exp2.delete();
    en0_cyc   = -1;
    busy0_cnt = 0;
  endtask

  task automatic do_reset();
    srst = 1'b1;
    wait_cyc(4);
    srst = 1'b0;
    wait_cyc(4);
  endtask

  // Frame-level reference: byte as sent, parity judged by total count of ones.
  function automatic logic [9:0] model(input logic [7:0] d, input bit par_en, input bit p,
                                       input bit odd, input bit stop);
    int  ones;
    bit  perr;
    ones = $countones({d, p});
    perr = par_en ? ((ones % 2) != (odd ? 1 : 0)) : 1'b0;
    return {d, perr, ~stop};
  endfunction

  // Drives one frame; bit k ends at (k+1)*SR*(100+off)/100 cycles to emulate baud skew.
  task automatic send_frame(input logic [7:0] d, input bit par_en, input bit p,
                            input bit stop, input int off);
    logic bits [11];
    int   nb;
    int   prev_end;
    int   cur_end;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    nb = 9;
    if (par_en) begin
      bits[9] = p;
      nb = 10;
    end
    bits[nb] = stop;
    nb = nb + 1;
    prev_end = 0;
    for (int k = 0; k < nb; k++) begin
      rxd = bits[k];
      cur_end = ((k + 1) * SR * (100 + off)) / 100;
      repeat (cur_end - prev_end) @(negedge clk);
      prev_end = cur_end;
    end
  endtask

  task automatic idle_bits(input int n);
    rxd = 1'b1;
    wait_cyc(n * SR);
  endtask

  task automatic check_q(input string tag, input int d);
    logic [9:0] o;
    logic [9:0] e;
    int no;
    int ne;
    case (d)
      0:       begin no = obs0.size(); ne = exp0.size(); end
      1:       begin no = obs1.size(); ne = exp1.size(); end
      default: begin no = obs2.size(); ne = exp2.size(); end
    endcase
    chk({tag, "_strobe_count"}, 32'(no), 32'(ne));
    for (int i = 0; i < ne && i < no; i++) begin
      case (d)
        0:       begin o = obs0[i]; e = exp0[i]; end
        1:       begin o = obs1[i]; e = exp1[i]; end
        default: begin o = obs2[i]; e = exp2[i]; end
      endcase
      chk($sformatf("%s_frame%0d_{byte,perr,ferr}", tag, i), 32'(o), 32'(e));
    end
    clear_q();
  endtask

  initial begin
    int t0;
    int lat;
    logic [7:0] d;
    bit stop;
    bit p;
    int off;
    int gap;
    logic [7:0] b2b [3];

    srst = 1'b1;
    rxd  = 1'b1;
    clear_q();
    wait_cyc(5);
    chk("reset_dout",  32'(dout0), 32'h0);
    chk("reset_en",    32'(en0),   32'h0);
    chk("reset_perr",  32'(pe0),   32'h0);
    chk("reset_ferr",  32'(fe0),   32'h0);
    chk("reset_busy",  32'(busy0), 32'h0);
    srst = 1'b0;
    wait_cyc(8);

    // Single good frame: data, flags, latency and busy window.
    clear_q();
    exp0.push_back(model(8'hA5, 0, 0, 0, 1));
    t0 = cyc;
    send_frame(8'hA5, 0, 0, 1, 0);
    idle_bits(2);
    lat = en0_cyc - t0;
    chk($sformatf("t1_latency_in_610_612(lat=%0d)", lat), 32'(lat >= 610 && lat <= 612), 32'h1);
    chk("t1_busy_cycles", 32'(busy0_cnt), 32'(9 * SR));
    check_q("t1", 0);

    // Short glitch is rejected, then the receiver still takes a frame.
    rxd = 1'b0;
    wait_cyc(20);
    idle_bits(3);
    chk("t2_glitch_busy_cycles", 32'(busy0_cnt), 32'h0);
    check_q("t2_glitch", 0);
    exp0.push_back(model(8'h5A, 0, 0, 0, 1));
    send_frame(8'h5A, 0, 0, 1, 0);
    idle_bits(2);
    check_q("t2_after", 0);

    // Bad stop followed by a long break: one strobe, then clean recovery.
    exp0.push_back(model(8'hFF, 0, 0, 0, 0));
    send_frame(8'hFF, 0, 0, 0, 0);
    wait_cyc(3 * 10 * SR);
    chk("t3_ferr_held", 32'(fe0), 32'h1);
    idle_bits(2);
    exp0.push_back(model(8'h3C, 0, 0, 0, 1));
    send_frame(8'h3C, 0, 0, 1, 0);
    idle_bits(2);
    check_q("t3", 0);

    // Parity checking, even and odd receivers on the same line.
    do_reset();
    clear_q();
    for (int i = 0; i < 2; i++) begin
      p = (i == 0);
      exp1.push_back(model(8'h07, 1, p, 0, 1));
      exp2.push_back(model(8'h07, 1, p, 1, 1));
      send_frame(8'h07, 1, p, 1, 0);
      idle_bits(2);
    end
    check_q("t4_even", 1);
    check_q("t4_odd", 2);

    // Back-to-back frames with the sender at -3% and +3% baud.
    do_reset();
    clear_q();
    b2b[0] = 8'h00;
    b2b[1] = 8'h55;
    b2b[2] = 8'hFF;
    for (int s = 0; s < 2; s++) begin
      off = (s == 0) ? -3 : 3;
      for (int i = 0; i < 3; i++) begin
        exp0.push_back(model(b2b[i], 0, 0, 0, 1));
        send_frame(b2b[i], 0, 0, 1, off);
      end
      idle_bits(2);
      check_q($sformatf("t5_b2b_off%0d", off), 0);
    end

    // Reset mid data bit 4 aborts the frame.
    clear_q();
    fork
      send_frame(8'hF0, 0, 0, 1, 0);
      begin
        wait_cyc(352);
        chk("t6_busy_before_srst", 32'(busy0), 32'h1);
        srst = 1'b1;
        wait_cyc(1);
        srst = 1'b0;
        chk("t6_dout_after_srst", 32'(dout0), 32'h0);
        chk("t6_en_after_srst",   32'(en0),   32'h0);
        chk("t6_perr_after_srst", 32'(pe0),   32'h0);
        chk("t6_ferr_after_srst", 32'(fe0),   32'h0);
        chk("t6_busy_after_srst", 32'(busy0), 32'h0);
      end
    join
    idle_bits(2);
    check_q("t6_abort", 0);
    exp0.push_back(model(8'h81, 0, 0, 0, 1));
    send_frame(8'h81, 0, 0, 1, 0);
    idle_bits(2);
    check_q("t6_next", 0);

    // Random stream: skewed baud, occasional bad stop bits, variable idle gaps.
    do_reset();
    clear_q();
    for (int i = 0; i < 20; i++) begin
      d    = 8'($urandom);
      off  = int'($urandom_range(0, 6)) - 3;
      stop = ($urandom_range(0, 4) != 0);
      gap  = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3));
      exp0.push_back(model(d, 0, 0, 0, stop));
      send_frame(d, 0, 0, stop, off);
      if (gap > 0) idle_bits(gap);
    end
    idle_bits(2);
    check_q("rand_plain", 0);

    // Random parity frames for both parity modes.
    do_reset();
    clear_q();
    for (int i = 0; i < 12; i++) begin
      d   = 8'($urandom);
      p   = 1'($urandom);
      off = int'($urandom_range(0, 6)) - 3;
      gap = int'($urandom_range(0, 1));
      exp1.push_back(model(d, 1, p, 0, 1));
      exp2.push_back(model(d, 1, p, 1, 1));
      send_frame(d, 1, p, 1, off);
      if (gap > 0) idle_bits(gap);
    end
    idle_bits(2);
    for (int i = 0; i < exp2.size(); i++) exp0.push_back(exp2[i]);
    exp0.delete();
    check_q("rand_even", 1);
    clear_q();

    // Re-run a short odd-parity burst so the odd receiver is checked independently.
    do_reset();
    clear_q();
    for (int i = 0; i < 6; i++) begin
      d   = 8'($urandom);
      p   = 1'($urandom);
      exp2.push_back(model(d, 1, p, 1, 1));
      send_frame(d, 1, p, 1, 0);
    end
    idle_bits(2);
    check_q("rand_odd", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
